// File: rtl/tsv_link_pkg.sv
// tsv_link_pkg
// Shared definitions for both ends of a TSV tier crossing. The transmit
// serializer and the receive deserializer both import this package.
//   tsv_state_e : link FSM states (PAR is only reached when
//                 TSV_LINK_PARITY_EN is defined)
//   nbeat()      : number of data beats per frame
//   beat_cnt_w() : width of the beat counter, never below 1 bit
package tsv_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2
  } tsv_state_e;

  function automatic int nbeat(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  function automatic int beat_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tsv_parity_fold.sv
// tsv_parity_fold
// Lane-wise XOR accumulator for the optional parity beat. The accumulator is
// cleared when a new bundle is accepted, and every consumed data beat is
// folded into it. acc_next is the value the accumulator takes on the coming
// edge. The serializer registers acc_next directly into its parity-beat
// output, so the last data beat is already folded in by then.
// Ports:
//   clk1     : clock, rising edge
//   rst      : asynchronous active-high reset
//   clr      : clear the accumulator (bundle accepted)
//   fold     : XOR beat into the accumulator (beat consumed)
//   beat     : beat currently on the lanes
//   acc_next : accumulator value after this edge
//   acc      : registered accumulator
module tsv_parity_fold #(
  parameter int LANE_W = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              clr,
  input  logic              fold,
  input  logic [LANE_W-1:0] beat,
  output logic [LANE_W-1:0] acc_next,
  output logic [LANE_W-1:0] acc
);

  always_comb begin
    acc_next = acc;
    if (clr) begin
      acc_next = '0;
    end else if (fold) begin
      acc_next = acc ^ beat;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/tsv_tier_serializer.sv
// tsv_tier_serializer
// Transmit-side tier-crossing serializer. A DATA_W-bit bundle from the
// producing tier is sent over LANE_W TSV lanes as DATA_W/LANE_W beats,
// LSB-first, with a start-of-frame strobe. The far tier can hold the current
// beat with tsv_stall. Frames run back to back when in_valid is held.
// Optional macro TSV_LINK_PARITY_EN appends a parity beat (the lane-wise XOR
// of all data beats) to every frame.
// Ports:
//   clk1      : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : producer presents a bundle
//   in_ready  : bundle accepted when in_valid && in_ready (combinational)
//   in_data   : bundle contents
//   tsv_data  : current beat on the lanes
//   tsv_vld   : tsv_data is a valid beat
//   tsv_sof   : first beat of a frame
//   tsv_par   : current beat is the parity beat (0 without the macro)
//   tsv_stall : far-tier backpressure; the current beat is held
//   busy      : a frame is in flight
//   frame_cnt : completed frames, wraps
module tsv_tier_serializer
  import tsv_link_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [LANE_W-1:0] tsv_data,
  output logic              tsv_vld,
  output logic              tsv_sof,
  output logic              tsv_par,
  input  logic              tsv_stall,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int NBEAT = nbeat(DATA_W, LANE_W);
  localparam int BW    = beat_cnt_w(NBEAT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  tsv_state_e        state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [BW-1:0]     beat_cnt, beat_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              final_beat;
  logic              accept;
  logic              frame_end;

  logic [LANE_W-1:0] data_d;
  logic              vld_d;
  logic              sof_d;
  logic              par_d;

`ifdef TSV_LINK_PARITY_EN
  logic [LANE_W-1:0] par_next;
  logic [LANE_W-1:0] par_acc;

  // Every accept starts a new frame, so accept alone clears the accumulator.
  // Only data beats are folded in; the parity beat itself is not.
  tsv_parity_fold #(
    .LANE_W (LANE_W)
  ) u_parity_fold (
    .clk1     (clk1),
    .rst      (rst),
    .clr      (accept),
    .fold     ((state == SEND) && !tsv_stall),
    .beat     (shift[LANE_W-1:0]),
    .acc_next (par_next),
    .acc      (par_acc)
  );

  assign final_beat = (state == PAR);
`else
  assign final_beat = (state == SEND) && (beat_cnt == LAST_BEAT);
`endif

  // in_ready depends combinationally on tsv_stall. This lets a new bundle be
  // accepted on the same edge that retires the last beat, so frames follow
  // each other with no gap.
  assign in_ready = !rst && ((state == IDLE) || (final_beat && !tsv_stall));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    beat_d    = beat_cnt;
    cnt_d     = frame_cnt;
    frame_end = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          shift_d = in_data;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (!tsv_stall) begin
          shift_d = shift >> LANE_W;
          beat_d  = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
`ifdef TSV_LINK_PARITY_EN
            state_d = PAR;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
`ifdef TSV_LINK_PARITY_EN
      PAR: begin
        if (!tsv_stall) begin
          frame_end = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_end) begin
      cnt_d = frame_cnt + 1'b1;
      if (accept) begin
        state_d = SEND;
        shift_d = in_data;
        beat_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // The lane outputs are computed from the next state and registered, so no
  // input has a combinational path to the TSV array.
  always_comb begin
    data_d = '0;
    vld_d  = (state_d != IDLE);
    sof_d  = 1'b0;
    par_d  = 1'b0;
    case (state_d)
      SEND: begin
        data_d = shift_d[LANE_W-1:0];
        sof_d  = (beat_d == '0);
      end
`ifdef TSV_LINK_PARITY_EN
      PAR: begin
        data_d = par_next;
        par_d  = 1'b1;
      end
`endif
      default: begin
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      tsv_data  <= '0;
      tsv_vld   <= 1'b0;
      tsv_sof   <= 1'b0;
      tsv_par   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      shift     <= shift_d;
      beat_cnt  <= beat_d;
      frame_cnt <= cnt_d;
      tsv_data  <= data_d;
      tsv_vld   <= vld_d;
      tsv_sof   <= sof_d;
      tsv_par   <= par_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_tsv_tier_serializer.sv
// tb_tsv_tier_serializer
// Directed bench for tsv_tier_serializer at DATA_W=32, LANE_W=8, CNT_W=8.
// Follows TSV_LINK_PARITY_EN so the same bench covers both builds.
module tb_tsv_tier_serializer;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 8;
`ifdef TSV_LINK_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [LANE_W-1:0] tsv_data;
  logic              tsv_vld;
  logic              tsv_sof;
  logic              tsv_par;
  logic              tsv_stall = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  int nvec = 0;
  int nerr = 0;
  int exp_cnt = 0;

  tsv_tier_serializer #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tsv_data  (tsv_data),
    .tsv_vld   (tsv_vld),
    .tsv_sof   (tsv_sof),
    .tsv_par   (tsv_par),
    .tsv_stall (tsv_stall),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_in_ready got %0b want 0", in_ready);
    end
    nvec++;
    if ({tsv_vld, tsv_sof, tsv_par, busy} !== 4'b0000) begin
      nerr++; $display("FAIL reset_flags got vld/sof/par/busy=%b want 0000",
                       {tsv_vld, tsv_sof, tsv_par, busy});
    end
    nvec++;
    if (tsv_data !== 8'h00 || frame_cnt !== 8'h00) begin
      nerr++; $display("FAIL reset_data got data=%h cnt=%0d want 00/0", tsv_data, frame_cnt);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL reset_release got ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [5];
    exp_d = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    in_data  = 32'h11223344;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      nvec++;
      if (tsv_vld !== 1'b1 || tsv_data !== exp_d[i]) begin
        nerr++; $display("FAIL basic_beat%0d got vld=%0b data=%h want 1/%h", i, tsv_vld, tsv_data, exp_d[i]);
      end
      nvec++;
      if (tsv_sof !== (i == 0) || tsv_par !== (i == 4)) begin
        nerr++; $display("FAIL basic_flags%0d got sof=%0b par=%0b want %0b/%0b",
                         i, tsv_sof, tsv_par, (i == 0), (i == 4));
      end
      nvec++;
      if (in_ready !== (i == FL - 1) || busy !== 1'b1) begin
        nerr++; $display("FAIL basic_ready%0d got ready=%0b busy=%0b want %0b/1",
                         i, in_ready, busy, (i == FL - 1));
      end
      nvec++;
      if (frame_cnt !== CNT_W'(exp_cnt)) begin
        nerr++; $display("FAIL basic_cnt%0d got %0d want %0d", i, frame_cnt, exp_cnt);
      end
      tick;
    end
    exp_cnt++;
    nvec++;
    if (tsv_vld !== 1'b0 || busy !== 1'b0 || frame_cnt !== CNT_W'(exp_cnt)) begin
      nerr++; $display("FAIL basic_end got vld=%0b busy=%0b cnt=%0d want 0/0/%0d",
                       tsv_vld, busy, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall;
    logic [7:0] exp_d [5];
    exp_d = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    in_data  = 32'h11223344;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tsv_stall = 1'b1;
    #1;
    nvec++;
    if (tsv_data !== 8'h33 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL stall_enter got data=%h ready=%0b want 33/0", tsv_data, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      nvec++;
      if (tsv_vld !== 1'b1 || tsv_data !== 8'h33 || tsv_sof !== 1'b0) begin
        nerr++; $display("FAIL stall_hold%0d got vld=%0b data=%h sof=%0b want 1/33/0",
                         k, tsv_vld, tsv_data, tsv_sof);
      end
    end
    tsv_stall = 1'b0;
    for (int j = 2; j < FL; j++) begin
      tick;
      nvec++;
      if (tsv_vld !== 1'b1 || tsv_data !== exp_d[j]) begin
        nerr++; $display("FAIL stall_after%0d got vld=%0b data=%h want 1/%h", j, tsv_vld, tsv_data, exp_d[j]);
      end
    end
    // Stall on the final beat: no accept is possible until it is released.
    tsv_stall = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL stall_last_ready got %0b want 0", in_ready);
    end
    tick;
    nvec++;
    if (tsv_vld !== 1'b1 || tsv_data !== exp_d[FL-1] || frame_cnt !== CNT_W'(exp_cnt)) begin
      nerr++; $display("FAIL stall_last_hold got vld=%0b data=%h cnt=%0d want 1/%h/%0d",
                       tsv_vld, tsv_data, frame_cnt, exp_d[FL-1], exp_cnt);
    end
    tsv_stall = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL stall_last_release got %0b want 1", in_ready);
    end
    tick;
    exp_cnt++;
    nvec++;
    if (tsv_vld !== 1'b0 || frame_cnt !== CNT_W'(exp_cnt)) begin
      nerr++; $display("FAIL stall_end got vld=%0b cnt=%0d want 0/%0d", tsv_vld, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [10];
    logic       exp_s [10];
    logic       exp_p [10];
`ifdef TSV_LINK_PARITY_EN
    exp_d = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h04};
    exp_s = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    exp_p = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    exp_d = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00};
    exp_s = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    exp_p = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    in_data  = 32'hAABBCCDD;
    in_valid = 1'b1;
    tick;
    in_data = 32'h01020304;
    for (int i = 0; i < 2 * FL; i++) begin
      nvec++;
      if (tsv_vld !== 1'b1 || tsv_data !== exp_d[i] ||
          tsv_sof !== exp_s[i] || tsv_par !== exp_p[i]) begin
        nerr++; $display("FAIL b2b_beat%0d got vld=%0b data=%h sof=%0b par=%0b want 1/%h/%0b/%0b",
                         i, tsv_vld, tsv_data, tsv_sof, tsv_par, exp_d[i], exp_s[i], exp_p[i]);
      end
      if (i < FL) begin
        nvec++;
        if (in_ready !== (i == FL - 1)) begin
          nerr++; $display("FAIL b2b_ready%0d got %0b want %0b", i, in_ready, (i == FL - 1));
        end
      end
      tick;
      if (i == FL - 1) in_valid = 1'b0;
    end
    exp_cnt += 2;
    nvec++;
    if (tsv_vld !== 1'b0 || frame_cnt !== CNT_W'(exp_cnt)) begin
      nerr++; $display("FAIL b2b_end got vld=%0b cnt=%0d want 0/%0d", tsv_vld, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    in_data  = 32'h11223344;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    nvec++;
    if ({tsv_vld, tsv_sof, tsv_par, busy} !== 4'b0000 || tsv_data !== 8'h00) begin
      nerr++; $display("FAIL rstmid_out got vld/sof/par/busy=%b data=%h want 0000/00",
                       {tsv_vld, tsv_sof, tsv_par, busy}, tsv_data);
    end
    nvec++;
    if (frame_cnt !== 8'h00 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL rstmid_cnt got cnt=%0d ready=%0b want 0/0", frame_cnt, in_ready);
    end
    tick;
    rst = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL rstmid_release got ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
    in_data  = 32'h55667788;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    nvec++;
    if (tsv_vld !== 1'b1 || tsv_sof !== 1'b1 || tsv_data !== 8'h88) begin
      nerr++; $display("FAIL rstmid_new got vld=%0b sof=%0b data=%h want 1/1/88", tsv_vld, tsv_sof, tsv_data);
    end
    for (int k = 0; k < FL; k++) tick;
    exp_cnt++;
    nvec++;
    if (tsv_vld !== 1'b0 || frame_cnt !== CNT_W'(exp_cnt)) begin
      nerr++; $display("FAIL rstmid_end got vld=%0b cnt=%0d want 0/%0d", tsv_vld, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    int c;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 0;
    for (int f = 0; f < 257; f++) begin
      in_data  = 32'(f) * 32'h01010101;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      c = 0;
      while (busy && c < 20) begin
        tick;
        c++;
      end
      exp_cnt = (exp_cnt + 1) % 256;
      nvec++;
      if (c !== FL) begin
        nerr++; $display("FAIL wrap_len%0d got %0d cycles want %0d", f, c, FL);
      end
      if (f == 254 || f == 255 || f == 256) begin
        nvec++;
        if (frame_cnt !== CNT_W'(exp_cnt)) begin
          nerr++; $display("FAIL wrap_cnt%0d got %0d want %0d", f, frame_cnt, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
